sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised FIFO. Successor to the dual-clock FIFO top for paths where producer and consumer share one clock.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between a streaming producer and consumer inside one clock domain. Storage array is internal.

Parameters:
- DATA_WIDTH, 8: width of data_in/data_out.
- DEPTH, 16: number of entries; power of 2, minimum 4.
- AFULL_THRESH, DEPTH-2: almost_full asserted when count >= this value; range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserted when count <= this value; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- write_enable  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- read_enable  input  1  read request (FWFT: pop head word).
- data_out  output  DATA_WIDTH  read data.
- data_valid  output  1  data_out holds valid read data.
- fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- fill_level  output  $clog2(DEPTH)+1  current count, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- err_clear  input  1  clears overflow/underflow.

Behaviour:
- Interface as decided: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values, sampled at the clk edge with rst=1:
  - wptr = rptr = 0, count = 0.
  - fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0.
  - fill_level = 0, data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all contents. Storage array is not cleared.
- Pointers: $clog2(DEPTH)+1 bits with an MSB wrap bit. Address = low bits. Natural binary wrap at DEPTH.
- Write accept: wa = write_enable && !fifo_full. Memory written at wptr; wptr increments.
- Read accept: ra = read_enable && !fifo_empty. rptr increments.
- A write is never accepted while full, even with a same-cycle accepted read. The read proceeds; the write is rejected.
- A read is never accepted while empty, even with a same-cycle write. The write proceeds; the read is rejected.
- Count update: next_count = count + wa - ra. Simultaneous wa and ra leave count unchanged.
- All flags and fill_level are registered from next_count, so they are valid the cycle after the access. No combinational input-to-flag paths.
- FWFT=0:
  - On ra, data_out <= mem[rptr] at the same edge; data_valid = 1 for that one cycle.
  - Read latency is 1 clk.
  - data_out holds its last value when there is no read. data_valid = 0 otherwise.
- FWFT=1:
  - data_out = mem[rptr] continuously; data_valid = !fifo_empty.
  - A word written to an empty FIFO appears 1 cycle after the write edge.
  - read_enable acknowledges/pops the displayed word.
- Error flags:
  - overflow set on write_enable && fifo_full.
  - underflow set on read_enable && fifo_empty.
  - Both cleared by err_clear. Set wins over err_clear in the same cycle.
  - Rejected accesses never change pointers, count or memory.

Test Plan (DEPTH=8, DATA_WIDTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2, FWFT=0 unless noted):
- Reset then idle -> fifo_empty=1, almost_empty=1, fill_level=0, data_valid=0, data_out=0, overflow=0, underflow=0.
- Write 0x10..0x17 (8 cycles), then read 8 -> almost_empty drops when fill_level=3, almost_full rises at 6, fifo_full at 8. Reads return 0x10..0x17 in order, each with data_valid 1 cycle after read_enable. Ends with fifo_empty=1.
- Full FIFO, write 0xAA with read_enable same cycle -> read returns 0x10, write rejected, fill_level=7, overflow=1. Next read sequence does not contain 0xAA.
- Empty FIFO, read_enable with write 0x55 same cycle -> underflow=1, data_valid=0, fill_level=1. Next read returns 0x55. Then err_clear=1 for one cycle -> underflow=0.
- Pointer wrap: 20 continuous simultaneous write/read cycles after a one-word prefill -> fill_level stays 1 throughout, data order preserved across wrap, no error flags.
- FWFT=1: write 0x3C into empty FIFO -> next cycle data_out=0x3C, data_valid=1. Pulse read_enable -> next cycle data_valid=0, fifo_empty=1. Assert rst mid-stream with 5 entries -> next cycle fifo_empty=1, fill_level=0.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: producer/consumer handshake, data and status bundle for the FIFO
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                    write_enable;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    read_enable;
    logic                    err_clear;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_valid;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [$clog2(DEPTH):0]  fill_level;
    logic                    overflow;
    logic                    underflow;
    modport master (
        output write_enable, data_in, read_enable, err_clear,
        input  data_out, data_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
    modport slave (
        input  write_enable, data_in, read_enable, err_clear,
        output data_out, data_valid, fifo_full, fifo_empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered status flags, sticky errors and optional FWFT read
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input logic clk,
    input logic rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_wptr, r_rptr, r_count;
    logic [CW-1:0]         w_wptr_n, w_rptr_n, w_count_n;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic                  w_wa, w_ra;
    always_comb begin
        w_wa      = bus.write_enable && !r_full;
        w_ra      = bus.read_enable && !r_empty;
        w_wptr_n  = r_wptr + CW'(w_wa);
        w_rptr_n  = r_rptr + CW'(w_ra);
        w_count_n = w_wptr_n - w_rptr_n;
    end
    always_ff @(posedge clk) begin
        if (w_wa && !rst) r_mem[r_wptr[AW-1:0]] <= bus.data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_n;
            r_rptr   <= w_rptr_n;
            r_count  <= w_count_n;
            r_full   <= w_count_n == CW'(DEPTH);
            r_empty  <= w_count_n == '0;
            r_afull  <= w_count_n >= CW'(AFULL_THRESH);
            r_aempty <= w_count_n <= CW'(AEMPTY_THRESH);
            r_valid  <= w_ra;
            if (w_ra) r_dout <= r_mem[r_rptr[AW-1:0]];
            r_ovf    <= (bus.write_enable && r_full) || (r_ovf && !bus.err_clear);
            r_unf    <= (bus.read_enable && r_empty) || (r_unf && !bus.err_clear);
        end
    end
    assign bus.data_out     = FWFT != 0 ? (r_empty ? '0 : r_mem[r_rptr[AW-1:0]]) : r_dout;
    assign bus.data_valid   = FWFT != 0 ? !r_empty : r_valid;
    assign bus.fifo_full    = r_full;
    assign bus.fifo_empty   = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.fill_level   = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: queue-model scoreboard for standard and FWFT instances driven in lockstep
module tb_sync_fifo_ctrl;
    localparam int DW = 8;
    localparam int D  = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic we = 1'b0, re = 1'b0, ec = 1'b0;
    logic [DW-1:0] din = '0;
    always #5 clk = ~clk;
    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(D)) f0 ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(D)) f1 ();
    assign f0.write_enable = we;
    assign f0.data_in      = din;
    assign f0.read_enable  = re;
    assign f0.err_clear    = ec;
    assign f1.write_enable = we;
    assign f1.data_in      = din;
    assign f1.read_enable  = re;
    assign f1.err_clear    = ec;
    sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0))
        d0 (.clk(clk), .rst(rst), .bus(f0.slave));
    sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1))
        d1 (.clk(clk), .rst(rst), .bus(f1.slave));
    int n_chk = 0, n_fail = 0;
    bit mon_en = 0;
    int q[$];
    int exp_q[$];
    bit m_ovf = 0, m_unf = 0, m_vld = 0;
    int m_last = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic chk_flags(string p, logic [3:0] fl, logic fu, logic em, logic af, logic ae,
                             logic ov, logic un);
        chk({p, "_fill"}, 32'(fl), q.size());
        chk({p, "_full"}, 32'(fu), 32'(q.size() == D));
        chk({p, "_empty"}, 32'(em), 32'(q.size() == 0));
        chk({p, "_afull"}, 32'(af), 32'(q.size() >= 6));
        chk({p, "_aempty"}, 32'(ae), 32'(q.size() <= 2));
        chk({p, "_ovf"}, 32'(ov), 32'(m_ovf));
        chk({p, "_unf"}, 32'(un), 32'(m_unf));
    endtask
    task automatic cyc(bit r, bit w, logic [7:0] d, bit rd, bit e);
        bit full, empty, wa, ra;
        int v;
        rst = r; we = w; din = d; re = rd; ec = e;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_vld = 0; m_last = 0;
        end else begin
            full  = q.size() == D;
            empty = q.size() == 0;
            wa = w && !full;
            ra = rd && !empty;
            m_ovf = (w && full) || (m_ovf && !e);
            m_unf = (rd && empty) || (m_unf && !e);
            m_vld = ra;
            if (ra) begin
                v = q.pop_front();
                exp_q.push_back(v);
                m_last = v;
            end
            if (wa) q.push_back(int'(d));
        end
        #1;
    endtask
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk_flags("std", f0.fill_level, f0.fifo_full, f0.fifo_empty, f0.almost_full,
                      f0.almost_empty, f0.overflow, f0.underflow);
            chk_flags("fwft", f1.fill_level, f1.fifo_full, f1.fifo_empty, f1.almost_full,
                      f1.almost_empty, f1.overflow, f1.underflow);
            chk("std_valid", 32'(f0.data_valid), 32'(m_vld));
            if (f0.data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL std_rdata: got %0h with no read outstanding", f0.data_out);
                end else chk("std_rdata", 32'(f0.data_out), exp_q.pop_front());
            end else chk("std_hold", 32'(f0.data_out), m_last);
            chk("fwft_valid", 32'(f1.data_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("fwft_head", 32'(f1.data_out), q[0]);
        end
    end
    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        mon_en = 1;
        repeat (2) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0);
        cyc(0, 1, 8'hAA, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 8'h55, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 8'h70, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 8'(8'h80 + i), 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 8'h3C, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        for (int p = 0; p < 8; p++) begin
            repeat (50) cyc($urandom_range(0, 99) == 0,
                            $urandom_range(0, 99) < (p % 2 == 0 ? 80 : 25),
                            8'($urandom),
                            $urandom_range(0, 99) < (p % 2 == 0 ? 25 : 80),
                            $urandom_range(0, 15) == 0);
        end
        cyc(0, 0, 0, 0, 1);
        while (q.size() != 0) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'hC0 + i), 0, 0);
        cyc(1, 1, 8'hEE, 1, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(0, 0, 0, 0, 0);
        chk("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
